cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Grants up to three Common Data Bus lanes per cycle among eight functional units (FUs) that have a finished result. It sits between the FU array and `complete_stage`. It drives `fu_c_stall` back to every losing FU, and presents a registered, lane-packed `FU_COMPLETE_PACKET [2:0]` to `complete_stage` for CDB broadcast and writeback. Rotating priority guarantees that no FU starves.

## Interface
- `NUM_FU`, 8, number of requesting FUs; equals the width of `FU_STATE_PACKET`.
- `CDB_W`, 3, number of CDB lanes.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fu_finish`  in  `FU_STATE_PACKET` (8)  bit i = FU i holds a valid result this cycle.
- `fu_packet`  in  `FU_COMPLETE_PACKET [7:0]`  result of each FU (`if_take_branch`, `dest_pr`, `dest_value`).
- `squash`  in  1  pipeline flush (mispredict recovery).
- `fu_c_stall`  out  `FU_STATE_PACKET` (8)  bit i = 1: FU i was not granted and must hold its packet.
- `cdb_valid`  out  3  lane k carries a valid result.
- `fu_c_out`  out  `FU_COMPLETE_PACKET [2:0]`  lane payloads, feeds `complete_stage.fu_c_in`.
- `grant_fu`  out  `[2:0][2:0]`  FU index occupying each lane (debug/ROB tagging).

## Operation
- **Grant search**
  - Order is circular from `rr_ptr` (3-bit): `rr_ptr`, `rr_ptr+1`, … mod 8.
  - The first requester found takes lane 0, the second lane 1, the third lane 2.
  - Lanes are filled densely from lane 0; unused lanes are invalid.
- **Stall**
  - `fu_c_stall[i] = fu_finish[i] & ~granted[i]`.
  - Non-requesting FUs see 0.
  - A stalled FU must keep `fu_finish` and `fu_packet` stable until granted. The arbiter does not buffer losers.
- **Pointer update**
  - When at least one grant occurs, `rr_ptr` ← (index of the last granted FU + 1) mod 8, with natural 3-bit wrap.
  - With no grant, `rr_ptr` holds.
- **Squash**
  - The cycle `squash`=1 makes no grants, so `fu_c_stall = fu_finish`.
  - At the next edge: `cdb_valid` ← 0, `fu_c_out` ← 0, `rr_ptr` ← 0.
  - Squash takes priority over every other event in that cycle.
- **Fewer than three requesters:** all are granted; stall is 0 everywhere.
- **No requesters:** `cdb_valid` ← 0 next edge; `fu_c_out` and `grant_fu` are don't-care but zeroed.

## Timing
- `fu_c_stall` is combinational from `fu_finish`, `rr_ptr` and `squash`, valid in the same cycle.
- `cdb_valid`, `fu_c_out` and `grant_fu` are registered: a grant in cycle N appears in cycle N+1. Latency is 1.
- `rr_ptr` updates at the same edge.
- Reset (`reset_n`=0, asynchronous):
  - `rr_ptr`=0, `cdb_valid`=0, `fu_c_out`=0, `grant_fu`=0.
  - While in reset, `fu_c_stall = fu_finish` (no grants).
- Reset deassertion mid-request: arbitration starts from `rr_ptr`=0 on the first edge after release.
- Throughput: three results per cycle sustained. A continuously requesting FU waits at most ⌈7/3⌉ = 3 cycles for a grant.

## Configuration
- `CDB_ARB_BRANCH_PRIO_EN` defined:
  - Requesters whose `fu_packet[i].if_take_branch`=1 are searched first, in circular order from `rr_ptr`.
  - The remaining requesters then fill the leftover lanes in circular order from `rr_ptr`.
  - The `rr_ptr` update still uses the highest-rotation-position granted FU.
- Not defined: pure round-robin; `if_take_branch` is ignored by the arbiter.

## Structure
- The shared package holds:
  - `FU_STATE_PACKET`, `FU_COMPLETE_PACKET` and `CDB_T_PACKET`.
  - `` `NUM_FU `` and `` `CDB_W `` constants.
  - A `FU_IDX` typedef (3 bits).
- One sub-module, `rr_pick3`: combinational circular first-3 selector.
  - Inputs: request vector, start pointer.
  - Outputs: three one-hot grants, their valids, and the last-granted index.
  - With branch priority enabled it is instantiated twice: the branch pass, then the remaining pass on masked requests.

## Test plan
- **Reset, full request:** hold `reset_n`=0 with `fu_finish`=`8'hFF`.
  - `fu_c_stall`=`8'hFF`, `cdb_valid`=`3'b000`.
  - After release, first edge: grants FU0, FU1, FU2; `fu_c_stall`=`8'hF8`; `rr_ptr`→3.
- **Saturated rotation:** `fu_finish`=`8'hFF` for 3 cycles.
  - Lane sets are {0,1,2}, {3,4,5}, {6,7,0}; `rr_ptr` takes 3, 6, 1.
  - `grant_fu` matches one cycle later.
- **Sparse request:** `fu_finish`=`8'b01010111`, `rr_ptr`=0.
  - Grants FU0, FU1, FU2; `fu_c_stall`=`8'b01010000`.
  - Next cycle, with the same requests minus the granted ones, grants FU4 and FU6; lane 2 invalid.
- **Payload routing:** FU5 `dest_pr`=6'b101110, `dest_value`=32'h091ec84b as the only requester.
  - Next cycle lane 0 carries exactly that packet; `cdb_valid`=`3'b001`; `grant_fu[0]`=5.
- **Squash:** `squash`=1 with `fu_finish`=`8'b10100001`.
  - `fu_c_stall`=`8'b10100001`; next cycle `cdb_valid`=0 and `rr_ptr`=0.
- **Branch priority** (`CDB_ARB_BRANCH_PRIO_EN`): `rr_ptr`=0, `fu_finish`=`8'hFF`, only FU7 with `if_take_branch`=1.
  - Lanes are FU7, FU0, FU1.
  - Without the macro: FU0, FU1, FU2.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared types, constants and helpers for the Common Data Bus arbiter.
//   NUM_FU             : number of requesting functional units (8)
//   CDB_W              : number of CDB lanes (3)
//   FU_IDX             : 3-bit functional unit index
//   FU_STATE_PACKET    : one bit per functional unit
//   FU_COMPLETE_PACKET : result carried on a CDB lane
//   CDB_T_PACKET       : per-lane tag (valid + owning FU)
package cdb_arbiter_pkg;

  localparam int NUM_FU = 8;
  localparam int CDB_W  = 3;

  typedef logic [2:0]        FU_IDX;
  typedef logic [NUM_FU-1:0] FU_STATE_PACKET;

  typedef struct packed {
    logic        if_take_branch;
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic  valid;
    FU_IDX fu;
  } CDB_T_PACKET;

  // Encode a one-hot FU vector into its index (0 when the vector is empty).
  function automatic FU_IDX onehot_to_idx(input FU_STATE_PACKET oh);
    FU_IDX idx;
    idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (oh[i]) idx = idx | FU_IDX'(i);
    end
    return idx;
  endfunction

  // Of the set bits in mask, return the one reached last when walking
  // circularly from start. Returns start when mask is empty.
  function automatic FU_IDX last_in_rotation(input FU_STATE_PACKET mask,
                                             input FU_IDX          start);
    FU_IDX idx;
    FU_IDX last;
    last = start;
    for (int off = 0; off < NUM_FU; off++) begin
      idx = start + FU_IDX'(off);
      if (mask[idx]) last = idx;
    end
    return last;
  endfunction

endpackage

// File: rtl/cdb_arbiter_pick3.sv
// rr_pick3
// Combinational circular first-three selector.
//   req      in  : request vector, one bit per FU
//   ptr      in  : FU index where the circular search starts
//   grant    out : one-hot grant per lane, lanes filled densely from lane 0
//   valid    out : lane k holds a grant
//   last_idx out : FU index of the last grant found (ptr when none)
module rr_pick3
  import cdb_arbiter_pkg::*;
(
  input  FU_STATE_PACKET                   req,
  input  FU_IDX                            ptr,
  output logic [CDB_W-1:0][NUM_FU-1:0]     grant,
  output logic [CDB_W-1:0]                 valid,
  output FU_IDX                            last_idx
);

  FU_IDX      idx;
  logic [1:0] cnt;

  always_comb begin
    grant    = '0;
    valid    = '0;
    last_idx = ptr;
    idx      = '0;
    cnt      = '0;
    for (int off = 0; off < NUM_FU; off++) begin
      // 3-bit addition wraps naturally, giving the circular order.
      idx = ptr + FU_IDX'(off);
      if (req[idx] && (cnt != 2'(CDB_W))) begin
        grant[cnt][idx] = 1'b1;
        valid[cnt]      = 1'b1;
        last_idx        = idx;
        cnt             = cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Grants up to three CDB lanes per cycle among eight functional units using a
// rotating-priority search, stalls the losers, and registers a lane-packed
// result bundle for complete_stage.
//   clock       in  : system clock, rising edge
//   reset_n     in  : asynchronous active-low reset
//   fu_finish   in  : bit i = FU i holds a finished result
//   fu_packet   in  : result of each FU
//   squash      in  : pipeline flush; no grants this cycle, pointer reset
//   fu_c_stall  out : bit i = FU i requested but was not granted (combinational)
//   cdb_valid   out : lane k carries a valid result (registered)
//   fu_c_out    out : lane payloads (registered)
//   grant_fu    out : FU index occupying each lane (registered)
// Optional feature macro: CDB_ARB_BRANCH_PRIO_EN -- requesters with
// if_take_branch set are searched first; the rest fill remaining lanes.
//
// Handshake: fu_finish[i] acts as valid, ~fu_c_stall[i] as ready. A transfer
// happens in a cycle where fu_finish[i]=1 and fu_c_stall[i]=0. While stalled,
// FU i must hold fu_finish[i] and fu_packet[i] stable; nothing is buffered here.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                                clock,
  input  logic                                reset_n,
  input  FU_STATE_PACKET                      fu_finish,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0]      fu_packet,
  input  logic                                squash,
  output FU_STATE_PACKET                      fu_c_stall,
  output logic [CDB_W-1:0]                    cdb_valid,
  output FU_COMPLETE_PACKET [CDB_W-1:0]       fu_c_out,
  output logic [CDB_W-1:0][2:0]               grant_fu
);

  FU_IDX                          rr_ptr;
  logic                           grant_en;
  FU_STATE_PACKET                 req;
  logic [CDB_W-1:0][NUM_FU-1:0]   lane_grant;
  logic [CDB_W-1:0]               lane_valid;
  FU_IDX                          last_idx;
  FU_STATE_PACKET                 granted;
  CDB_T_PACKET [CDB_W-1:0]        lane_tag;
  FU_COMPLETE_PACKET [CDB_W-1:0]  lane_pkt;

  // Nothing is granted during reset or squash, so every requester stalls.
  assign grant_en = reset_n & ~squash;
  assign req      = grant_en ? fu_finish : '0;

`ifdef CDB_ARB_BRANCH_PRIO_EN
  FU_STATE_PACKET                 br_req;
  FU_STATE_PACKET                 br_granted;
  FU_STATE_PACKET                 rest_req;
  logic [CDB_W-1:0][NUM_FU-1:0]   br_grant;
  logic [CDB_W-1:0][NUM_FU-1:0]   rest_grant;
  logic [CDB_W-1:0]               br_valid;
  logic [CDB_W-1:0]               rest_valid;
  FU_IDX                          br_last;
  FU_IDX                          rest_last;

  always_comb begin
    br_req = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      br_req[i] = req[i] & fu_packet[i].if_take_branch;
    end
  end

  rr_pick3 u_pick_br (
    .req      (br_req),
    .ptr      (rr_ptr),
    .grant    (br_grant),
    .valid    (br_valid),
    .last_idx (br_last)
  );

  assign br_granted = br_grant[0] | br_grant[1] | br_grant[2];
  assign rest_req   = req & ~br_granted;

  rr_pick3 u_pick_rest (
    .req      (rest_req),
    .ptr      (rr_ptr),
    .grant    (rest_grant),
    .valid    (rest_valid),
    .last_idx (rest_last)
  );

  // Branch grants occupy the low lanes; the second pass fills what is left.
  always_comb begin
    lane_grant = rest_grant;
    lane_valid = rest_valid;
    case (br_valid)
      3'b001: begin
        lane_grant = {rest_grant[1], rest_grant[0], br_grant[0]};
        lane_valid = {rest_valid[1], rest_valid[0], 1'b1};
      end
      3'b011: begin
        lane_grant = {rest_grant[0], br_grant[1], br_grant[0]};
        lane_valid = {rest_valid[0], 2'b11};
      end
      3'b111: begin
        lane_grant = br_grant;
        lane_valid = 3'b111;
      end
      default: begin
        lane_grant = rest_grant;
        lane_valid = rest_valid;
      end
    endcase
  end

  // Grants come from two passes, so the furthest-rotated one is recomputed
  // over the merged set rather than taken from either pass.
  assign last_idx = last_in_rotation(granted, rr_ptr);
`else
  rr_pick3 u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .grant    (lane_grant),
    .valid    (lane_valid),
    .last_idx (last_idx)
  );
`endif

  assign granted    = lane_grant[0] | lane_grant[1] | lane_grant[2];
  assign fu_c_stall = fu_finish & ~granted;

  // Next lane contents; unused lanes are forced to zero.
  always_comb begin
    FU_IDX idx;
    idx      = '0;
    lane_tag = '0;
    lane_pkt = '0;
    for (int k = 0; k < CDB_W; k++) begin
      idx               = onehot_to_idx(lane_grant[k]);
      lane_tag[k].valid = lane_valid[k];
      if (lane_valid[k]) begin
        lane_tag[k].fu = idx;
        lane_pkt[k]    = fu_packet[idx];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      fu_c_out  <= '0;
      grant_fu  <= '0;
    end else if (squash) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      fu_c_out  <= '0;
      grant_fu  <= '0;
    end else begin
      for (int k = 0; k < CDB_W; k++) begin
        cdb_valid[k] <= lane_tag[k].valid;
        grant_fu[k]  <= lane_tag[k].fu;
        fu_c_out[k]  <= lane_pkt[k];
      end
      // Resume just past the furthest-rotated winner so skipped FUs lead next.
      if (|lane_valid) rr_ptr <= last_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Directed and random stimulus for cdb_arbiter with a scoreboard of expected
// lane bundles and pointer values. Honours CDB_ARB_BRANCH_PRIO_EN when defined.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

`ifdef CDB_ARB_BRANCH_PRIO_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif
  localparam int EXP_W = CDB_W + CDB_W * 3 + CDB_W * $bits(FU_COMPLETE_PACKET);

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  FU_STATE_PACKET                 fu_finish;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_packet;
  logic                           squash;
  FU_STATE_PACKET                 fu_c_stall;
  logic [CDB_W-1:0]               cdb_valid;
  FU_COMPLETE_PACKET [CDB_W-1:0]  fu_c_out;
  logic [CDB_W-1:0][2:0]          grant_fu;

  cdb_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fu_finish  (fu_finish),
    .fu_packet  (fu_packet),
    .squash     (squash),
    .fu_c_stall (fu_c_stall),
    .cdb_valid  (cdb_valid),
    .fu_c_out   (fu_c_out),
    .grant_fu   (grant_fu)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [2:0]       ptr_q[$];
  logic [2:0]       m_ptr;
  logic [7:0]       m_stall;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: pass 0 takes branch requesters (when enabled),
  // pass 1 takes everyone else, both walking circularly from ptr.
  function automatic void model_pick(input logic [7:0] req, input logic [7:0] br,
                                     input logic [2:0] ptr, input logic sq,
                                     output logic [2:0] vld, output logic [2:0][2:0] idxs,
                                     output logic [2:0] nxt);
    int n;
    int best;
    logic [7:0] taken;
    vld = '0; idxs = '0; nxt = ptr; n = 0; best = -1; taken = '0;
    if (sq) begin
      nxt = '0;
      return;
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int s = 0; s < 8; s++) begin
        int f;
        f = (int'(ptr) + s) % 8;
        if (req[f] && !taken[f] && n < 3 && (pass == 1 || (BR_EN && br[f]))) begin
          taken[f] = 1'b1;
          vld[n]   = 1'b1;
          idxs[n]  = 3'(f);
          n++;
          if (s > best) best = s;
        end
      end
    end
    if (n > 0) nxt = 3'((int'(ptr) + best + 1) % 8);
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive inputs, predict, check stall.
  task automatic apply(input logic [7:0] fin, input logic sq);
    logic [2:0]                    vld;
    logic [2:0][2:0]               idxs;
    logic [2:0]                    nxt;
    logic [7:0]                    br;
    FU_COMPLETE_PACKET [CDB_W-1:0] pay;
    fu_finish = fin;
    squash    = sq;
    for (int i = 0; i < NUM_FU; i++) br[i] = fu_packet[i].if_take_branch;
    model_pick(fin, br, m_ptr, sq, vld, idxs, nxt);
    m_stall = fin;
    pay     = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (vld[k]) begin
        m_stall[idxs[k]] = 1'b0;
        pay[k]           = fu_packet[idxs[k]];
      end
    end
    exp_q.push_back({vld, idxs, pay});
    ptr_q.push_back(nxt);
    m_ptr = nxt;
    #1;
    check("stall", 160'(fu_c_stall), 160'(m_stall));
  endtask

  // Let the edge happen, compare registered outputs, return at falling edge.
  task automatic settle();
    logic [EXP_W-1:0] e;
    logic [2:0]       p;
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    p = ptr_q.pop_front();
    check("lanes", 160'({cdb_valid, grant_fu, fu_c_out}), 160'(e));
    check("rr_ptr", 160'(dut.rr_ptr), 160'(p));
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] r_fin;
  logic       r_sq;

  initial begin
    // ---- reset with all FUs requesting ----
    reset_n   = 1'b0;
    squash    = 1'b0;
    fu_finish = 8'hFF;
    for (int i = 0; i < NUM_FU; i++)
      fu_packet[i] = {1'b0, 6'(i + 8), 32'hA000_0000 + 32'(i)};
    m_ptr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_stall", 160'(fu_c_stall), 160'(8'hFF));
    check("rst_valid", 160'(cdb_valid), 160'(3'b000));
    check("rst_grant", 160'(grant_fu), 160'(9'd0));
    check("rst_out", 160'(fu_c_out), 160'(0));
    check("rst_ptr", 160'(dut.rr_ptr), 160'(3'd0));

    // ---- release, saturated rotation ----
    reset_n = 1'b1;
    apply(8'hFF, 1'b0);
    check("sat0_stall", 160'(fu_c_stall), 160'(8'hF8));
    settle();
    check("sat0_grant", 160'(grant_fu), 160'({3'd2, 3'd1, 3'd0}));
    check("sat0_ptr", 160'(dut.rr_ptr), 160'(3'd3));
    apply(8'hFF, 1'b0);
    settle();
    check("sat1_grant", 160'(grant_fu), 160'({3'd5, 3'd4, 3'd3}));
    check("sat1_ptr", 160'(dut.rr_ptr), 160'(3'd6));
    apply(8'hFF, 1'b0);
    settle();
    check("sat2_grant", 160'(grant_fu), 160'({3'd0, 3'd7, 3'd6}));
    check("sat2_ptr", 160'(dut.rr_ptr), 160'(3'd1));

    // ---- squash ----
    apply(8'b10100001, 1'b1);
    check("sq_stall", 160'(fu_c_stall), 160'(8'b10100001));
    settle();
    check("sq_valid", 160'(cdb_valid), 160'(3'b000));
    check("sq_ptr", 160'(dut.rr_ptr), 160'(3'd0));

    // ---- sparse request ----
    apply(8'b01010111, 1'b0);
    check("sp0_stall", 160'(fu_c_stall), 160'(8'b01010000));
    settle();
    check("sp0_grant", 160'(grant_fu), 160'({3'd2, 3'd1, 3'd0}));
    apply(8'b01010000, 1'b0);
    check("sp1_stall", 160'(fu_c_stall), 160'(8'b00000000));
    settle();
    check("sp1_valid", 160'(cdb_valid), 160'(3'b011));
    check("sp1_grant", 160'(grant_fu[1:0]), 160'({3'd6, 3'd4}));

    // ---- payload routing ----
    fu_packet[5] = {1'b0, 6'b101110, 32'h091ec84b};
    apply(8'b00100000, 1'b0);
    settle();
    check("pay_lane0", 160'(fu_c_out[0]), 160'({1'b0, 6'b101110, 32'h091ec84b}));
    check("pay_valid", 160'(cdb_valid), 160'(3'b001));
    check("pay_fu", 160'(grant_fu[0]), 160'(3'd5));

    // ---- no requesters ----
    apply(8'h00, 1'b0);
    settle();
    check("idle_valid", 160'(cdb_valid), 160'(3'b000));
    check("idle_ptr", 160'(dut.rr_ptr), 160'(3'd6));

    // ---- branch priority: rr_ptr back to 0, only FU7 branches ----
    apply(8'h00, 1'b1);
    settle();
    for (int i = 0; i < NUM_FU; i++) fu_packet[i].if_take_branch = (i == 7);
    apply(8'hFF, 1'b0);
    settle();
`ifdef CDB_ARB_BRANCH_PRIO_EN
    check("br_grant", 160'(grant_fu), 160'({3'd1, 3'd0, 3'd7}));
`else
    check("br_grant", 160'(grant_fu), 160'({3'd2, 3'd1, 3'd0}));
`endif

    // ---- random traffic; stalled FUs keep requesting with stable packets ----
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!m_stall[i])
          fu_packet[i] = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 32'($urandom)};
      end
      r_fin = m_stall | 8'($urandom_range(0, 255));
      r_sq  = ($urandom_range(0, 15) == 0);
      apply(r_fin, r_sq);
      settle();
    end

    // ---- asynchronous reset in the middle of traffic ----
    apply(8'hFF, 1'b0);
    settle();
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 160'(cdb_valid), 160'(3'b000));
    check("arst_grant", 160'(grant_fu), 160'(9'd0));
    check("arst_out", 160'(fu_c_out), 160'(0));
    check("arst_ptr", 160'(dut.rr_ptr), 160'(3'd0));
    check("arst_stall", 160'(fu_c_stall), 160'(8'hFF));
    @(negedge clock);
    reset_n = 1'b1;
    m_ptr   = '0;
    for (int i = 0; i < NUM_FU; i++) fu_packet[i].if_take_branch = 1'b0;
    apply(8'hFF, 1'b0);
    check("rel_stall", 160'(fu_c_stall), 160'(8'hF8));
    settle();
    check("rel_grant", 160'(grant_fu), 160'({3'd2, 3'd1, 3'd0}));

    check("queue_empty", 160'(exp_q.size()), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
